sram_stream_loader: RTL

//  Synthesisable SRAM initialiser and checker. Fills a contiguous SRAM region from a byte stream
//  (boot UART or flash reader). Packs bytes little-endian into words, then issues single-cycle

---
 rtl/sram_stream_loader_pkg.sv | 20 ++
 rtl/sram_stream_loader_byte_packer.sv | 44 ++++
 rtl/sram_stream_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_loader_pkg.sv
// Shared types and constants for the SRAM stream loader and its byte packer.
package sram_stream_loader_pkg;

   localparam int BYTE_W = 8;

   localparam logic LD_WRITE  = 1'b0;
   localparam logic LD_VERIFY = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_COLLECT,
      ST_WRITE,
      ST_READ,
      ST_WAIT,
      ST_CMP,
      ST_FIN
   } loader_state_t;

endpackage

// File: rtl/sram_stream_loader_byte_packer.sv
// Packs a byte stream little-endian into words: the first byte of a word ends up
// in the least significant byte once the word is complete.
module sram_stream_loader_byte_packer
   import sram_stream_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_byte_valid,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_last
);

   localparam int NB   = WORD_W / BYTE_W;
   localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

   logic [BC_W-1:0]   r_count;
   logic [WORD_W-1:0] r_word;
   logic [WORD_W-1:0] w_shifted;

   // New bytes enter at the top and drift down, so byte 0 lands in bits [7:0].
   assign w_shifted = (r_word >> BYTE_W) | (WORD_W'(i_byte) << (WORD_W - BYTE_W));

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
         r_word  <= '0;
      end else if (i_byte_valid) begin
         r_word <= w_shifted;
         if (o_last) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_word = r_word;
   assign o_last = (r_count == BC_W'(NB - 1));

endmodule

// File: rtl/sram_stream_loader.sv
// Fills or verifies a contiguous SRAM region from a byte stream, one word at a time,
// with single-cycle write/read strobes and a saturating mismatch counter.
module sram_stream_loader
   import sram_stream_loader_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_num_words,
   input  logic              i_in_valid,
   input  logic [BYTE_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_addr_ready,
   output logic              o_sram_write_pulse,
   output logic              o_sram_read_pulse,
   output logic [WORD_W-1:0] o_sram_datain,
   input  logic [WORD_W-1:0] i_sram_dataout,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_range_err,
   output logic [CNT_W-1:0]  o_mismatch_cnt,
   output logic [ADDR_W-1:0] o_first_mm_addr
);

   localparam int WAIT_W = 3;

   loader_state_t     r_state;
   logic              r_mode;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_num;
   logic [ADDR_W:0]   r_left;
   logic [WAIT_W-1:0] r_wait;
   logic              r_in_ready;
   logic [ADDR_W-1:0] r_addr;
   logic              r_addr_ready;
   logic              r_wr_pulse;
   logic              r_rd_pulse;
   logic              r_busy;
   logic              r_done;
   logic              r_range_err;
   logic [CNT_W-1:0]  r_mm_cnt;
   logic [ADDR_W-1:0] r_first_mm;

   logic              w_accept;
   logic              w_clear;
   logic              w_last;
   logic [WORD_W-1:0] w_word;
   logic [ADDR_W+1:0] w_end;
   logic              w_mismatch;

   assign w_accept   = i_in_valid && r_in_ready;
   assign w_clear    = (r_state == ST_IDLE) && i_start;
   // One extra bit of headroom keeps base+num from overflowing before the compare.
   assign w_end      = {2'b00, r_base} + {1'b0, r_num};
   assign w_mismatch = (i_sram_dataout != w_word);

   sram_stream_loader_byte_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_clear),
      .i_byte_valid (w_accept),
      .i_byte       (i_in_data),
      .o_word       (w_word),
      .o_last       (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_mode       <= LD_WRITE;
         r_base       <= '0;
         r_num        <= '0;
         r_left       <= '0;
         r_wait       <= '0;
         r_in_ready   <= 1'b0;
         r_addr       <= '0;
         r_addr_ready <= 1'b0;
         r_wr_pulse   <= 1'b0;
         r_rd_pulse   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_range_err  <= 1'b0;
         r_mm_cnt     <= '0;
         r_first_mm   <= '0;
      end else begin
         r_wr_pulse <= 1'b0;
         r_rd_pulse <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mode      <= i_mode;
                  r_base      <= i_base_addr;
                  r_num       <= i_num_words;
                  r_mm_cnt    <= '0;
                  r_range_err <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_end > (ADDR_W+2)'(DEPTH)) begin
                  r_range_err <= 1'b1;
                  r_done      <= 1'b1;
                  r_state     <= ST_FIN;
               end else if (r_num == '0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_addr     <= r_base;
                  r_left     <= r_num;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (w_accept && w_last) begin
                  r_in_ready   <= 1'b0;
                  r_addr_ready <= 1'b1;
                  if (r_mode == LD_VERIFY) begin
                     r_rd_pulse <= 1'b1;
                     r_state    <= ST_READ;
                  end else begin
                     r_wr_pulse <= 1'b1;
                     r_state    <= ST_WRITE;
                  end
               end
            end
            ST_READ: begin
               if (RD_LAT > 1) begin
                  r_wait  <= WAIT_W'(RD_LAT - 2);
                  r_state <= ST_WAIT;
               end else begin
                  r_addr_ready <= 1'b0;
                  r_state      <= ST_CMP;
               end
            end
            ST_WAIT: begin
               if (r_wait == '0) begin
                  r_addr_ready <= 1'b0;
                  r_state      <= ST_CMP;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            ST_WRITE, ST_CMP: begin
               // Only the compare state scores read data; both then advance to the next word.
               if (r_state == ST_CMP && w_mismatch) begin
                  if (r_mm_cnt == '0) begin
                     r_first_mm <= r_addr;
                  end
                  if (r_mm_cnt != '1) begin
                     r_mm_cnt <= r_mm_cnt + 1'b1;
                  end
               end
               r_addr_ready <= 1'b0;
               if (r_left == (ADDR_W+1)'(1)) begin
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_addr     <= r_addr + 1'b1;
                  r_left     <= r_left - 1'b1;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_COLLECT;
               end
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready         = r_in_ready;
   assign o_sram_addr        = r_addr;
   assign o_sram_addr_ready  = r_addr_ready;
   assign o_sram_write_pulse = r_wr_pulse;
   assign o_sram_read_pulse  = r_rd_pulse;
   assign o_sram_datain      = w_word;
   assign o_busy             = r_busy;
   assign o_done             = r_done;
   assign o_range_err        = r_range_err;
   assign o_mismatch_cnt     = r_mm_cnt;
   assign o_first_mm_addr    = r_first_mm;

endmodule
